// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between NUM_REQ producers, the burst arbiter and the FIFO write port.
// master: arbiter view; slave: requester/FIFO environment view.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int IDX_WIDTH  = 2
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          full;
  logic                          w_en;
  logic [DATA_WIDTH-1:0]         fifo_wdata;
  logic                          grant_valid;
  logic [IDX_WIDTH-1:0]          grant_id;

  modport master (
    input  req_valid, req_data, full,
    output req_ready, w_en, fifo_wdata, grant_valid, grant_id
  );

  modport slave (
    output req_valid, req_data, full,
    input  req_ready, w_en, fifo_wdata, grant_valid, grant_id
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter feeding the async FIFO write port from NUM_REQ producers.
// One IDLE cycle arbitrates, then the winner owns the port for up to MAX_BURST beats.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int IDX_WIDTH  = 2,
  parameter int CNT_WIDTH  = 3
) (
  input  logic               wclk,
  input  logic               wrst_n,
  fifo_wr_arbiter_if.master  bus
);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_e;

  state_e                             state_q, state_d;
  logic [IDX_WIDTH-1:0]               gid_q, gid_d;
  logic [IDX_WIDTH-1:0]               rr_q, rr_d;
  logic                               gv_q, gv_d;
  logic [CNT_WIDTH-1:0]               cnt_q, cnt_d;

  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] data_arr;
  logic [IDX_WIDTH-1:0]               winner;
  logic [IDX_WIDTH-1:0]               gid_inc;
  logic                               any_req;
  logic                               gnt_vld;
  logic                               beat;
  logic                               last_beat;

  assign data_arr  = bus.req_data;
  assign gnt_vld   = bus.req_valid[gid_q];
  assign beat      = (state_q == BURST) & gnt_vld & ~bus.full;
  assign last_beat = beat & (cnt_q == CNT_WIDTH'(MAX_BURST-1));
  assign gid_inc   = (gid_q == IDX_WIDTH'(NUM_REQ-1)) ? '0 : gid_q + IDX_WIDTH'(1);

  // Scan downward in offset so the nearest valid bit at or above rr_q wins last.
  always_comb begin
    int                   j;
    logic [IDX_WIDTH-1:0] jx;
    winner  = rr_q;
    any_req = 1'b0;
    j       = 0;
    jx      = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      j = int'(rr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      jx = IDX_WIDTH'(j);
      if (bus.req_valid[jx]) begin
        winner  = jx;
        any_req = 1'b1;
      end
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q <= IDLE;
      gid_q   <= '0;
      rr_q    <= '0;
      gv_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      rr_q    <= rr_d;
      gv_q    <= gv_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gid_d   = gid_q;
    rr_d    = rr_q;
    gv_d    = gv_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = BURST;
          gid_d   = winner;
          gv_d    = 1'b1;
          cnt_d   = '0;
        end
      end
      BURST: begin
        if (beat) cnt_d = cnt_q + CNT_WIDTH'(1);
        // A full stall leaves everything frozen; only a drop or the final beat closes the burst.
        if (!gnt_vld || last_beat) begin
          state_d = IDLE;
          gv_d    = 1'b0;
          rr_d    = gid_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready   = '0;
    bus.w_en        = 1'b0;
    bus.fifo_wdata  = data_arr[gid_q];
    bus.grant_valid = gv_q;
    bus.grant_id    = gid_q;
    if (state_q == BURST) begin
      bus.req_ready[gid_q] = ~bus.full;
      bus.w_en             = beat;
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin burst arbiter that lets NUM_REQ independent producers share the single write port of the async FIFO.
- Sits entirely in the write clock domain, in front of the FIFO top.
- Drives the FIFO's w_en and data_in from the granted requester and backpressures every requester using the FIFO's full flag.
- Grants are held for bursts of up to MAX_BURST beats to reduce arbitration overhead.

Parameters:
- NUM_REQ, 4, number of requesters; must be 2 or more.
- DATA_WIDTH, 8, FIFO data width; must match the FIFO instance.
- MAX_BURST, 4, maximum beats accepted per grant; must be 1 or more.
- IDX_WIDTH, 2, width of the requester index; must equal ceil(log2(NUM_REQ)).
- CNT_WIDTH, 3, width of the beat counter; must hold the value MAX_BURST.

Ports:
- wclk  in  1  write-domain clock; all state updates on its rising edge.
- wrst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester valid; bit i belongs to requester i.
- req_data  in  NUM_REQ*DATA_WIDTH  per-requester data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  per-requester ready; a beat transfers when valid and ready are both high on a wclk edge.
- full  in  1  FIFO full flag from the write-pointer logic.
- w_en  out  1  FIFO write enable.
- fifo_wdata  out  DATA_WIDTH  FIFO write data.
- grant_valid  out  1  high while a burst is granted.
- grant_id  out  IDX_WIDTH  index of the current or last granted requester.

Behaviour:
- Interface: one clock (wclk); reset is asynchronous and active-low (wrst_n).
- Reset (asserted at any time, including mid-burst) forces the following immediately, with no clock needed:
  - state goes to IDLE;
  - grant_valid = 0, grant_id = 0;
  - round-robin pointer rr_ptr = 0;
  - beat counter = 0.
- Outputs during reset: w_en = 0 and req_ready = 0. Any burst in progress is abandoned; no partial write is issued.
- FSM has two states, IDLE and BURST.
- IDLE:
  - req_ready = 0 and w_en = 0.
  - If any req_valid bit is set, the winner is the first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - On the next edge: grant_id = winner, grant_valid = 1, beat counter = 0, state goes to BURST.
  - Arbitration latency is one cycle. full is not considered when granting.
- BURST:
  - req_ready[grant_id] = !full; all other req_ready bits are 0.
  - w_en = req_valid[grant_id] & !full; this is combinational, so the beat is written in the same cycle.
  - fifo_wdata is always the req_data slice selected by grant_id; its value is don't-care to the FIFO when w_en = 0.
  - Each cycle with w_en = 1 increments the beat counter.
  - The burst ends, going to IDLE on the next edge with grant_valid = 0 and rr_ptr = (grant_id + 1) mod NUM_REQ, when either:
    (a) a beat is accepted while counter == MAX_BURST-1, or
    (b) req_valid[grant_id] = 0 (no beat is written that cycle).
  - grant_id keeps its value in IDLE.
- full stall: while full = 1 in BURST the grant is held, the counter is frozen and no beat is written. There is no timeout.
- Requester contract: data must be held stable while valid is high and ready is low. Dropping valid ends the burst; it is not an error.
- Throughput: one burst of up to MAX_BURST beats per MAX_BURST+1 cycles, because each burst is followed by one IDLE arbitration cycle.
- Fairness: the last-served requester has lowest priority on the next arbitration. Every continuously requesting requester is served within NUM_REQ arbitrations.
- Simultaneous events:
  - A beat accepted on the final count coincident with valid dropping exits once, with the same result as either rule alone.
  - full rising in the same cycle as a would-be final beat: no beat is written and the burst stays open.
- Invariants: w_en implies grant_valid; at most one req_ready bit is high; w_en is never 1 while full = 1.

Test Plan:
- Requester 0 only, valid for 6 beats with data 0x10..0x15, full = 0:
  - grant_id = 0 one cycle after valid;
  - w_en high for 4 consecutive cycles writing 0x10..0x13, then 1 IDLE cycle;
  - regrant; 0x14, 0x15 written; then IDLE.
- All 4 requesters valid continuously: grants in order 0,1,2,3,0, each exactly 4 beats, one IDLE cycle between bursts.
- Requester 1 granted; full = 1 for 3 cycles after beat 2:
  - w_en = 0 and req_ready[1] = 0 during the stall; grant_id stays 1;
  - beats 3 and 4 complete after full falls; burst length stays 4.
- Requester 2 drops valid after 1 beat while requester 3 is valid: IDLE next cycle, then grant_id = 3; rr_ptr = 3 at that arbitration.
- Assert wrst_n = 0 mid-burst (beat 2 of requester 1):
  - w_en, req_ready and grant_valid go to 0 asynchronously;
  - after release with requesters 0 and 1 both valid, requester 0 is granted first.
- Scoreboard: random valid/full patterns with unique data per requester; every accepted beat appears on fifo_wdata exactly once, in per-requester order, and w_en is never high while full is high.
